// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch (IF) port and the data memory (DM) port of a pipelined core. One
//   memory transaction is outstanding at a time. DM has priority over IF, but
//   a streak counter bounds how many DM grants IF can lose in a row.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   if_req/if_addr      IF read request, held until if_ready
//   if_rdata/if_ready   IF read data, valid during the one-cycle if_ready pulse
//   dm_req/dm_we        DM request (write when dm_we=1), held until dm_ready
//   dm_addr/dm_wdata    DM byte address and write data
//   dm_rdata/dm_ready   DM read data, valid during the one-cycle dm_ready pulse
//   mem_req/mem_we      memory request (held until mem_ack) and write enable
//   mem_addr/mem_wdata  memory address and write data, stable while mem_req=1
//   mem_rdata/mem_ack   memory read data and one-cycle completion strobe
//   stallF/stallM       pending-request qualifiers for the hazard logic
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stallF,
  output logic             stallM
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] streak;
  logic       if_live;
  logic       dm_live;
  logic       pick_dm;
  logic       pick_if;

  // A port whose ready is high this cycle has just been served; masking it
  // keeps a still-asserted request from being issued a second time.
  assign if_live = if_req & ~if_ready;
  assign dm_live = dm_req & ~dm_ready;

  assign stallF = if_req & ~if_ready;
  assign stallM = dm_req & ~dm_ready;

  // DM wins contention unless IF has already lost LIMIT grants in a row.
  always_comb begin
    pick_dm = dm_live & (~if_live | (streak != LIMIT));
    pick_if = if_live & ~pick_dm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          // mem_ack is ignored here: nothing is outstanding.
          if (pick_dm) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_live)
              streak <= (streak == LIMIT) ? LIMIT : streak + 4'd1;
            else
              streak <= 4'd0;
          end else if (pick_if) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= 4'd0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_ready <= 1'b1;
            // A write completion leaves the last read data in place.
            if (!mem_we)
              dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a table of cycle vectors for the
//   directed scenarios, hand-written reset and starvation sequences, and a
//   randomized run scored against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int W   = 32;
  localparam int LIM = 4;
  localparam int OW  = 134;

  localparam logic [31:0] I1 = 32'h00500093;
  localparam logic [31:0] I2 = 32'h33334444;
  localparam logic [31:0] D1 = 32'h11112222;
  localparam logic [31:0] D2 = 32'h55667788;
  localparam logic [31:0] BF = 32'hDEADBEEF;
  localparam logic [31:0] WD = 32'h12345678;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req, if_ready, dm_req, dm_we, dm_ready;
  logic         mem_req, mem_we, mem_ack, stallF, stallM;
  logic [W-1:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [OW-1:0] obs;

  mem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallF(stallF), .stallM(stallM)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata,
                dm_ready, dm_rdata, stallF, stallM};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One vector = inputs applied in a cycle and the outputs expected in it.
  typedef struct {
    logic [31:0] ifr, ifa, dmr, dwe, dma, dwd, ack, mrd;
    logic [31:0] req, we, addr, wd, ifrdy, ifrd, dmrdy, dmrd, sf, sm;
  } vec_t;
  vec_t vecs[$];

  // Reference model state (transaction level).
  int          m_busy;   // 0 none, 1 IF outstanding, 2 DM outstanding
  int          m_streak;
  logic        m_req, m_we, m_ifrdy, m_dmrdy;
  logic [31:0] m_addr, m_wd, m_ifrd, m_dmrd;
  logic        p_ifr, p_dmr, p_dwe, p_ack, p_ifrdy, p_dmrdy;
  logic [31:0] p_ifa, p_dma, p_dwd, p_mrd;

  // Memory responder state.
  logic auto_mem, rand_lat, model_on, started;
  int   lat, wcnt;

  task automatic model_reset();
    m_busy = 0; m_streak = 0;
    m_req = 0; m_we = 0; m_ifrdy = 0; m_dmrdy = 0;
    m_addr = 0; m_wd = 0; m_ifrd = 0; m_dmrd = 0;
  endtask

  task automatic model_check();
    logic ui, ud;
    m_ifrdy = 0;
    m_dmrdy = 0;
    if (m_busy != 0) begin
      if (p_ack) begin
        if (m_busy == 1) begin
          m_ifrdy = 1;
          m_ifrd  = p_mrd;
        end else begin
          m_dmrdy = 1;
          if (!m_we) m_dmrd = p_mrd;
        end
        m_busy = 0; m_req = 0; m_we = 0;
      end
    end else begin
      ui = p_ifr & ~p_ifrdy;
      ud = p_dmr & ~p_dmrdy;
      if (ud && (!ui || m_streak < LIM)) begin
        m_busy = 2; m_req = 1; m_we = p_dwe; m_addr = p_dma; m_wd = p_dwd;
        m_streak = ui ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
      end else if (ui) begin
        m_busy = 1; m_req = 1; m_we = 0; m_addr = p_ifa; m_wd = 0;
        m_streak = 0;
      end
    end
    chk("model", obs, {m_req, m_we, m_addr, m_wd, m_ifrdy, m_ifrd, m_dmrdy, m_dmrd,
                       if_req & ~m_ifrdy, dm_req & ~m_dmrdy});
  endtask

  task automatic mem_drive();
    if (!mem_req) begin
      mem_ack   = 0;
      started   = 0;
      mem_rdata = $urandom;
    end else begin
      if (!started) begin
        started = 1;
        wcnt    = 0;
        lat     = rand_lat ? int'($urandom_range(0, 3)) : 0;
      end
      mem_rdata = $urandom;
      if (wcnt >= lat) mem_ack = 1;
      else begin
        mem_ack = 0;
        wcnt++;
      end
    end
  endtask

  task automatic run_cycle();
    if (auto_mem) mem_drive();
    p_ifr = if_req; p_dmr = dm_req; p_dwe = dm_we; p_ifa = if_addr;
    p_dma = dm_addr; p_dwd = dm_wdata; p_ack = mem_ack; p_mrd = mem_rdata;
    p_ifrdy = m_ifrdy; p_dmrdy = m_dmrdy;
    @(posedge clk); #1;
    if (model_on) model_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] da;
    int n_if, n_dm;

    // if-only read, then masking check
    vecs.push_back(vec_t'{1, 'h10, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back(vec_t'{1, 'h10, 0, 0, 0, 0, 1, I1,    1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back(vec_t'{1, 'h10, 0, 0, 0, 0, 0, 0,     0, 0, 'h10, 0, 1, I1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 'h10, 0, 0, 0, 0, 0, 0,     0, 0, 'h10, 0, 0, I1, 0, 0, 0, 0});
    // contention: DM first, IF granted in the dm_ready cycle
    vecs.push_back(vec_t'{1, 'h20, 1, 0, 'h200, 0, 0, 0,  0, 0, 'h10, 0, 0, I1, 0, 0, 1, 1});
    vecs.push_back(vec_t'{1, 'h20, 1, 0, 'h200, 0, 1, D1, 1, 0, 'h200, 0, 0, I1, 0, 0, 1, 1});
    vecs.push_back(vec_t'{1, 'h20, 1, 0, 'h200, 0, 0, 0,  0, 0, 'h200, 0, 0, I1, 1, D1, 1, 0});
    vecs.push_back(vec_t'{1, 'h20, 0, 0, 'h200, 0, 1, I2, 1, 0, 'h20, 0, 0, I1, 0, D1, 1, 0});
    vecs.push_back(vec_t'{1, 'h20, 0, 0, 'h200, 0, 0, 0,  0, 0, 'h20, 0, 1, I2, 0, D1, 0, 0});
    vecs.push_back(vec_t'{0, 'h20, 0, 0, 'h200, 0, 0, 0,  0, 0, 'h20, 0, 0, I2, 0, D1, 0, 0});
    // DM write with five busy cycles
    vecs.push_back(vec_t'{0, 0, 1, 1, 'h84, BF, 0, 0,     0, 0, 'h20, 0, 0, I2, 0, D1, 0, 1});
    for (int k = 0; k < 4; k++)
      vecs.push_back(vec_t'{0, 0, 1, 1, 'h84, BF, 0, 0,   1, 1, 'h84, BF, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 1, 'h84, BF, 1, 'hBADBAD00, 1, 1, 'h84, BF, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 1, 'h84, BF, 0, 0,     0, 0, 'h84, BF, 0, I2, 1, D1, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 'h84, BF, 0, 0,     0, 0, 'h84, BF, 0, I2, 0, D1, 0, 0});
    // requester inputs change while busy
    vecs.push_back(vec_t'{0, 0, 1, 0, 'h200, 0, 0, 0,     0, 0, 'h84, BF, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 'h300, 0, 0, 0,     1, 0, 'h200, 0, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 'h300, WD, 0, 0,    1, 0, 'h200, 0, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 'h300, WD, 1, D2,   1, 0, 'h200, 0, 0, I2, 0, D1, 0, 1});
    vecs.push_back(vec_t'{0, 0, 1, 0, 'h300, WD, 0, 0,    0, 0, 'h200, 0, 0, I2, 1, D2, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 'h300, WD, 0, 0,    0, 0, 'h200, 0, 0, I2, 0, D2, 0, 0});

    auto_mem = 0; rand_lat = 0; model_on = 0; started = 0; lat = 0; wcnt = 0;
    n_if = 0; n_dm = 0;
    model_reset();
    reset = 1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    chk("reset_state", obs, '0);
    reset = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if_req = vecs[i].ifr[0]; if_addr = vecs[i].ifa;
      dm_req = vecs[i].dmr[0]; dm_we = vecs[i].dwe[0];
      dm_addr = vecs[i].dma; dm_wdata = vecs[i].dwd;
      mem_ack = vecs[i].ack[0]; mem_rdata = vecs[i].mrd;
      #1;
      chk($sformatf("vec%0d", i), obs,
          {vecs[i].req[0], vecs[i].we[0], vecs[i].addr, vecs[i].wd,
           vecs[i].ifrdy[0], vecs[i].ifrd, vecs[i].dmrdy[0], vecs[i].dmrd,
           vecs[i].sf[0], vecs[i].sm[0]});
      @(posedge clk); #1;
    end

    // Reset while a DM read is outstanding, followed by a stray ack.
    dm_req = 1; dm_we = 0; dm_addr = 32'h180; dm_wdata = 0; mem_ack = 0;
    @(posedge clk); #1;
    chk("rst_pre_busy", obs, {1'b1, 1'b0, 32'h180, 32'h0, 1'b0, I2, 1'b0, D2, 1'b0, 1'b1});
    #2 reset = 1;
    #1;
    chk("rst_async", obs, OW'(2'b01));
    dm_req = 0;
    @(posedge clk); #1;
    reset = 0;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_after", obs, '0);
      @(posedge clk); #1;
    end

    // Starvation: IF competes in every fresh IDLE cycle but withdraws while
    // DM is busy, so the dm_ready cycle never hands the port to IF and the
    // streak builds up to the limit.
    model_reset();
    model_on = 1; auto_mem = 1; rand_lat = 0;
    for (int i = 0; i < 6; i++) begin
      da = 32'h100 + 32'(i * 4);
      if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = da; dm_wdata = 0;
      run_cycle();
      if (i == 4) begin
        chk("starve_if_grant", OW'(mem_addr), OW'(32'h40));
        run_cycle();
        if_req = 0;
        run_cycle();
        chk("starve_dm_after", OW'(mem_addr), OW'(da));
        run_cycle();
        dm_req = 0;
        run_cycle();
      end else begin
        chk("starve_dm_grant", OW'(mem_addr), OW'(da));
        if_req = 0;
        run_cycle();
        dm_req = 0;
        run_cycle();
      end
    end

    // Randomized traffic against the reference model.
    rand_lat = 1;
    for (int c = 0; c < 2500; c++) begin
      if (if_ready) begin
        n_if++;
        if_req = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_ready) begin
        n_dm++;
        dm_req = 1'($urandom_range(0, 1));
        dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      run_cycle();
    end
    chk("rand_if_progress", OW'(n_if > 20), OW'(1));
    chk("rand_dm_progress", OW'(n_dm > 20), OW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
